// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver: synchronises rx, frames bytes at mid-bit sample points and
// queues good bytes in a small first-word-fall-through FIFO drained with rd_en.
module uart_receiver #(
    parameter int unsigned CLKS_PER_TICK = 27,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] TickLast = CW'(CLKS_PER_TICK - 1);
    localparam logic [SW-1:0] ScntMid  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] ScntLast = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] tcnt_q;
    logic          tick;

    state_e        state_q;
    logic [SW-1:0] scnt_q;
    logic [2:0]    bitpos_q;
    logic [7:0]    shreg_q;
    logic          rx_busy_q, frame_err_q, overrun_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, stop_push, do_push, do_pop;

    // Both synchroniser flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick = (tcnt_q == TickLast);

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
        end else if (tick) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + CW'(1);
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            scnt_q      <= '0;
            bitpos_q    <= '0;
            shreg_q     <= '0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rx_s_q) begin
                            state_q   <= StStart;
                            scnt_q    <= '0;
                            rx_busy_q <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (scnt_q == ScntMid) begin
                            if (!rx_s_q) begin
                                state_q  <= StData;
                                scnt_q   <= '0;
                                bitpos_q <= '0;
                            end else begin
                                // Start bit did not survive to its midpoint: treat as a glitch.
                                state_q   <= StIdle;
                                rx_busy_q <= 1'b0;
                            end
                        end else begin
                            scnt_q <= scnt_q + SW'(1);
                        end
                    end
                    StData: begin
                        if (scnt_q == ScntLast) begin
                            shreg_q <= {rx_s_q, shreg_q[7:1]};
                            scnt_q  <= '0;
                            if (bitpos_q == 3'd7) begin
                                state_q <= StStop;
                            end else begin
                                bitpos_q <= bitpos_q + 3'd1;
                            end
                        end else begin
                            scnt_q <= scnt_q + SW'(1);
                        end
                    end
                    StStop: begin
                        if (scnt_q == ScntLast) begin
                            state_q     <= StIdle;
                            rx_busy_q   <= 1'b0;
                            frame_err_q <= ~rx_s_q;
                        end else begin
                            scnt_q <= scnt_q + SW'(1);
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        rx_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stop_push = tick && (state_q == StStop) && (scnt_q == ScntLast) && rx_s_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push = stop_push && (!full || do_pop);

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            overrun_q <= stop_push && full && !do_pop;
        end
    end

    assign dout      = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid  = !empty;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Oversampling 8N1 UART receiver: the serial-to-parallel counterpart of the team's UART transmitter. It synchronises the asynchronous `rx` line and detects and validates the start bit. It samples each data bit at its midpoint, LSB first, and checks the stop bit. Good bytes go into a small first-word-fall-through FIFO that the host logic drains with `rd_en`.

## Interface
- `CLKS_PER_TICK`, default 27: system_clk cycles per oversample tick (50 MHz / (115200 × 16) ≈ 27); must be ≥ 2.
- `OVERSAMPLE`, default 16: ticks per bit period; even, ≥ 8.
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, ≥ 2.

Ports:
- `system_clk`  in  1  single clock; every flop is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; asynchronous; idle high.
- `rd_en`  in  1  pops the FIFO head when `rx_valid`=1; ignored when empty.
- `dout`  out  8  FIFO head byte (first-word fall-through).
- `rx_valid`  out  1  FIFO non-empty.
- `rx_busy`  out  1  receive FSM not in IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun`  out  1  one-cycle pulse: good byte arrived with FIFO full, byte dropped.

## Operation
- Synchroniser:
  - `rx` passes through two flops, both reset to 1, giving `rx_s`.
  - Every decision below uses `rx_s` only.
- Tick generator:
  - Free-running counter 0..CLKS_PER_TICK-1; resets to 0.
  - `tick` is a one-cycle pulse on the cycle the counter equals CLKS_PER_TICK-1.
- FSM state:
  - FSM states are IDLE, START, DATA and STOP.
  - State only advances on `tick` cycles.
  - Sample counter `scnt` is log2(OVERSAMPLE) bits; `bitpos` is 3 bits; shift register is 8 bits.
- IDLE:
  - On tick with `rx_s`=0: go to START, `scnt`←0.
- START:
  - On each tick, `scnt`++.
  - At `scnt`=OVERSAMPLE/2-1 (the midpoint of the start bit):
    - if `rx_s`=0: go to DATA, `scnt`←0, `bitpos`←0;
    - otherwise: glitch, return to IDLE with nothing reported.
- DATA:
  - On each tick, `scnt`++.
  - At `scnt`=OVERSAMPLE-1: shift right, `shreg[7]`←`rx_s`, `scnt`←0.
  - If `bitpos`=7 go to STOP, else `bitpos`++.
  - After 8 bits, `shreg` holds the byte LSB-first-received.
- STOP:
  - At `scnt`=OVERSAMPLE-1 (the midpoint of the stop bit), always return to IDLE.
  - If `rx_s`=1, push `shreg` into the FIFO.
  - If `rx_s`=0, pulse `frame_err` and push nothing.
  - Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
- FIFO:
  - `FIFO_DEPTH` × 8 storage; read/write pointers carry one extra wrap bit.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
  - `dout` = mem[rd_ptr].
  - Push when full and `rd_en`=0: byte dropped, `overrun` pulses, FIFO unchanged.
  - Push and `rd_en` in the same cycle when full: both happen, no overrun.
  - Push and `rd_en` in the same cycle when empty: the push happens and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `dout`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
  - FSM=IDLE; all counters and pointers 0; FIFO storage zeroed.
- Reset asserted mid-byte: everything returns to the reset values immediately (asynchronously) and the partial byte is lost.
- Input latency: 2 cycles through the synchroniser.
- Start detection jitter: up to 1 tick, so sampling lands within ±1 tick of the bit centre.
- Output latency:
  - The push occurs on the STOP decision tick.
  - `rx_valid` and `dout` are valid on the next cycle.
- Read side: `rd_en` on cycle n → the next entry appears on `dout` at n+1 and `rx_valid` updates at n+1.
- `frame_err` and `overrun` assert on the cycle after the STOP decision tick, for exactly one cycle.
- `rx_busy` = (state ≠ IDLE), registered from the state; it rises one cycle after the start-detect tick.

## Test plan
All scenarios use CLKS_PER_TICK=4, OVERSAMPLE=16, FIFO_DEPTH=4, so one bit = 64 clocks.
- Single byte: send 0x55 in 8N1, then pulse `rd_en` → `rx_valid`=1 with `dout`=0x55; after the read, `rx_valid`=0; `frame_err` and `overrun` never assert.
- Start glitch: drive `rx` low for 20 clocks, then high → no push, `rx_busy` returns to 0 within 8 ticks, `rx_valid` stays 0.
- Framing error: send 0xA3 with the stop bit driven 0 → exactly one `frame_err` pulse, `rx_valid` stays 0; a following 0x3C (correct framing) is received as 0x3C.
- Overrun: send 0x01..0x05 with no reads → one `overrun` pulse, on the 5th byte; four reads return 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
- Back-to-back and simultaneous push/pop:
  - Send 0x00, 0xFF, 0x81 with no idle gap → all three received in order.
  - With the FIFO full, hold `rd_en`=1 across a push → no overrun, count unchanged.
- Reset mid-byte: pull `reset` low during bit 3 of 0xF0 → all outputs return to reset values at once; after release, 0x3C is received correctly and 0xF0 never appears.
